// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory and holds the core in reset
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [31:0] MAX_LEN = MAX_BYTES;
  state_t state, state_nxt;
  logic [31:0] len, count, len_nxt, count_nxt;
  logic [7:0] sum;
  logic [1:0] hcnt;
  logic acc, launch;
  assign busy       = state == LEN || state == DATA || state == CSUM;
  assign byte_ready = busy;
  assign done       = state == DONE;
  assign error      = state == ERR;
  assign core_rst_n = state == DONE;
  assign acc        = byte_valid && byte_ready;
  assign launch     = start && !busy;
  // length header arrives MSB first, so shift each byte in from the bottom
  assign len_nxt    = {len[23:0], byte_data};
  assign count_nxt  = count + 32'd1;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: state_nxt = start ? LEN : state;
      LEN:  if (acc && hcnt == 2'd3) state_nxt = (len_nxt == 32'd0 || len_nxt > MAX_LEN) ? ERR : DATA;
      DATA: if (acc && count_nxt == len) state_nxt = CSUM;
      CSUM: if (acc) state_nxt = byte_data == sum ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= '0;
      count     <= '0;
      sum       <= '0;
      hcnt      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= acc && state == DATA;
      if (launch) begin
        len   <= '0;
        count <= '0;
        sum   <= '0;
        hcnt  <= '0;
      end
      if (acc && state == LEN) begin
        len  <= len_nxt;
        hcnt <= hcnt + 2'd1;
      end
      if (acc && state == DATA) begin
        mem_addr  <= BASE_ADDR + count;
        mem_wdata <= byte_data;
        count     <= count_nxt;
        sum       <= sum + byte_data;
      end
    end
  end
endmodule
